// File: rtl/spram_ctrl.sv
// ============================================================================
// spram_ctrl : load/store request controller for the single-port data SPRAM
//              (sub-word stores done as read-modify-write)
// Revision   : 1.0
// ============================================================================
`default_nettype none

module spram_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [14:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_rd_en,
  output logic [14:0] mem_addr,
  input  logic [31:0] mem_rd_data,
  input  logic        mem_rd_valid,
  output logic        mem_wr_en,
  output logic [31:0] mem_wr_data
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WAIT = 3'd2,
    S_WR   = 3'd3,
    S_RESP = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [14:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        w_req_err;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_merged;

  // Misaligned or illegal-size requests complete immediately with an error.
  always_comb begin
    w_req_err = 1'b0;
    case (req_size)
      2'd0:    w_req_err = 1'b0;
      2'd1:    w_req_err = req_addr[0];
      2'd2:    w_req_err = (req_addr[1:0] != 2'b00);
      default: w_req_err = 1'b1;
    endcase
  end

  // Lane extraction for loads and lane merge for sub-word stores.
  always_comb begin
    w_byte = mem_rd_data[7:0];
    case (addr_q[1:0])
      2'd0:    w_byte = mem_rd_data[7:0];
      2'd1:    w_byte = mem_rd_data[15:8];
      2'd2:    w_byte = mem_rd_data[23:16];
      default: w_byte = mem_rd_data[31:24];
    endcase
    w_half = addr_q[1] ? mem_rd_data[31:16] : mem_rd_data[15:0];

    w_load = mem_rd_data;
    case (size_q)
      2'd0:    w_load = {{24{signed_q & w_byte[7]}}, w_byte};
      2'd1:    w_load = {{16{signed_q & w_half[15]}}, w_half};
      default: w_load = mem_rd_data;
    endcase

    w_merged = mem_rd_data;
    if (size_q == 2'd0) begin
      case (addr_q[1:0])
        2'd0:    w_merged[7:0]   = wdata_q[7:0];
        2'd1:    w_merged[15:8]  = wdata_q[7:0];
        2'd2:    w_merged[23:16] = wdata_q[7:0];
        default: w_merged[31:24] = wdata_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      w_merged[31:16] = wdata_q[15:0];
    end else begin
      w_merged[15:0]  = wdata_q[15:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    size_d   = size_q;
    signed_d = signed_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          size_d   = req_size;
          signed_d = req_signed;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          rdata_d  = 32'h0;
          err_d    = w_req_err;
          if (w_req_err) begin
            state_d = S_RESP;
          end else if (req_we && (req_size == 2'd2)) begin
            state_d = S_WR;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD: state_d = S_WAIT;
      S_WAIT: begin
        if (mem_rd_valid) begin
          if (we_q) begin
            wdata_d = w_merged;
            state_d = S_WR;
          end else begin
            rdata_d = w_load;
            state_d = S_RESP;
          end
        end
      end
      S_WR:    state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      size_q   <= 2'd0;
      signed_q <= 1'b0;
      addr_q   <= 15'h0;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Strobes decode purely from the state register so reset drops them at once.
  assign req_ready   = (state_q == S_IDLE);
  assign mem_rd_en   = (state_q == S_RD);
  assign mem_wr_en   = (state_q == S_WR);
  assign resp_valid  = (state_q == S_RESP);
  assign resp_rdata  = resp_valid ? rdata_q : 32'h0;
  assign resp_err    = resp_valid & err_q;
  assign mem_addr    = addr_q;
  assign mem_wr_data = req_ready ? 32'h0 : wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_spram_ctrl.sv
// Directed self-checking bench for spram_ctrl with a behavioural SPRAM model.
`default_nettype none

module tb_spram_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_signed = 1'b0;
  logic [14:0] req_addr = 15'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_rd_en;
  logic [14:0] mem_addr;
  logic [31:0] mem_rd_data;
  logic        mem_rd_valid;
  logic        mem_wr_en;
  logic [31:0] mem_wr_data;

  int n_cmp = 0;
  int n_bad = 0;

  spram_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_signed   (req_signed),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_rd_en    (mem_rd_en),
    .mem_addr     (mem_addr),
    .mem_rd_data  (mem_rd_data),
    .mem_rd_valid (mem_rd_valid),
    .mem_wr_en    (mem_wr_en),
    .mem_wr_data  (mem_wr_data)
  );

  always #5 clk = ~clk;

  // SPRAM model: registered read, rd_valid 1+extra cycles after rd_en.
  logic [31:0] mem [0:15] = '{4: 32'h8899AABB, default: 32'h0};
  logic [3:0]  vpipe = 4'h0;
  logic [31:0] rdq = 32'h0;
  int          extra = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          both_cnt = 0;
  logic [31:0] last_wr_data = 32'h0;
  logic [14:0] last_wr_addr = 15'h0;

  always @(posedge clk) begin
    vpipe <= {vpipe[2:0], mem_rd_en};
    if (mem_rd_en) begin
      rdq    <= mem[mem_addr[5:2]];
      rd_cnt <= rd_cnt + 1;
    end
    if (mem_wr_en) begin
      mem[mem_addr[5:2]] <= mem_wr_data;
      wr_cnt       <= wr_cnt + 1;
      last_wr_data <= mem_wr_data;
      last_wr_addr <= mem_addr;
    end
    if (mem_rd_en && mem_wr_en) both_cnt <= both_cnt + 1;
  end

  assign mem_rd_valid = vpipe[extra];
  assign mem_rd_data  = rdq;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one request, returns edges-to-response (accept edge counts as 1),
  // the response fields, and whether the pulse lasted one cycle back to IDLE.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [14:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic er,
                        output logic one_cycle);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = resp_rdata;
    er = resp_err;
    @(posedge clk); #1;
    one_cycle = !resp_valid && req_ready;
  endtask

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        er;
    logic        oc;
    int          rb, wb;
    logic        seen;

    #1 rst = 1'b1;
    #2;
    chk("rst_ready",  req_ready,   1);
    chk("rst_rvalid", resp_valid,  0);
    chk("rst_rdata",  resp_rdata,  0);
    chk("rst_err",    resp_err,    0);
    chk("rst_rd_en",  mem_rd_en,   0);
    chk("rst_wr_en",  mem_wr_en,   0);
    chk("rst_addr",   mem_addr,    0);
    chk("rst_wdata",  mem_wr_data, 0);
    @(negedge clk); rst = 1'b0;

    // Loads from word 0x10 = 0x8899AABB
    do_req(0, 2'd0, 1, 15'h11, 32'h0, lat, rd, er, oc);
    chk("lb_s_lat", lat, 3); chk("lb_s_data", rd, 32'hFFFFFFAA);
    chk("lb_s_err", er, 0);  chk("lb_s_pulse", oc, 1);
    do_req(0, 2'd0, 0, 15'h11, 32'h0, lat, rd, er, oc);
    chk("lb_u_data", rd, 32'h000000AA);
    do_req(0, 2'd1, 1, 15'h12, 32'h0, lat, rd, er, oc);
    chk("lh_s_data", rd, 32'hFFFF8899);
    do_req(0, 2'd0, 1, 15'h10, 32'h0, lat, rd, er, oc);
    chk("lb_s_pos", rd, 32'hFFFFFFBB);

    // Half store at 0x12 via read-modify-write
    rb = rd_cnt; wb = wr_cnt;
    do_req(1, 2'd1, 0, 15'h12, 32'h12345678, lat, rd, er, oc);
    chk("sh_lat", lat, 4);          chk("sh_rdata", rd, 0);
    chk("sh_rd_n", rd_cnt - rb, 1); chk("sh_wr_n", wr_cnt - wb, 1);
    chk("sh_wdata", last_wr_data, 32'h5678AABB);
    chk("sh_pulse", oc, 1);
    do_req(0, 2'd2, 0, 15'h10, 32'h0, lat, rd, er, oc);
    chk("lw_after_sh", rd, 32'h5678AABB);

    // Word store at 0x20
    rb = rd_cnt; wb = wr_cnt;
    do_req(1, 2'd2, 0, 15'h20, 32'hDEADBEEF, lat, rd, er, oc);
    chk("sw_lat", lat, 2);          chk("sw_rdata", rd, 0);
    chk("sw_err", er, 0);
    chk("sw_rd_n", rd_cnt - rb, 0); chk("sw_wr_n", wr_cnt - wb, 1);
    chk("sw_addr", last_wr_addr, 15'h20);
    chk("sw_mem", mem[8], 32'hDEADBEEF);

    // Byte store at lane 3 of 0x20
    do_req(1, 2'd0, 0, 15'h23, 32'hFFFFFF11, lat, rd, er, oc);
    chk("sb_mem", mem[8], 32'h11ADBEEF);

    // Errors: no memory traffic, one-edge response
    rb = rd_cnt; wb = wr_cnt;
    do_req(0, 2'd2, 0, 15'h13, 32'h0, lat, rd, er, oc);
    chk("e_lw_lat", lat, 1); chk("e_lw_err", er, 1); chk("e_lw_data", rd, 0);
    do_req(0, 2'd1, 1, 15'h01, 32'h0, lat, rd, er, oc);
    chk("e_lh_lat", lat, 1); chk("e_lh_err", er, 1); chk("e_lh_data", rd, 0);
    do_req(1, 2'd3, 0, 15'h10, 32'hCAFEF00D, lat, rd, er, oc);
    chk("e_sz3_lat", lat, 1); chk("e_sz3_err", er, 1);
    chk("e_sz3_pulse", oc, 1);
    chk("e_rd_n", rd_cnt - rb, 0); chk("e_wr_n", wr_cnt - wb, 0);
    chk("e_mem", mem[4], 32'h5678AABB);

    // Byte store aborted by reset during WAIT
    wb = wr_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 15'h10; req_wdata = 32'h55;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("ab_in_rd", mem_rd_en, 1);
    @(posedge clk); #1;
    chk("ab_wait_ready", req_ready, 0);
    #2 rst = 1'b1;
    #1;
    chk("ab_ready",  req_ready,   1);
    chk("ab_rvalid", resp_valid,  0);
    chk("ab_rd_en",  mem_rd_en,   0);
    chk("ab_wr_en",  mem_wr_en,   0);
    chk("ab_addr",   mem_addr,    0);
    chk("ab_wdata",  mem_wr_data, 0);
    @(negedge clk); rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (resp_valid || mem_wr_en) seen = 1'b1;
    end
    chk("ab_quiet", seen, 0);
    chk("ab_wr_n", wr_cnt - wb, 0);
    chk("ab_mem", mem[4], 32'h5678AABB);
    chk("ab_ready_after", req_ready, 1);

    // req_valid held across a word load
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 15'h10; req_wdata = 32'h0;
    @(posedge clk); #1;
    chk("bp_rd_ready", req_ready, 0); chk("bp_rd_en", mem_rd_en, 1);
    @(posedge clk); #1;
    chk("bp_wait_ready", req_ready, 0);
    @(posedge clk); #1;
    chk("bp_resp_valid", resp_valid, 1); chk("bp_resp_ready", req_ready, 0);
    chk("bp_resp_data", resp_rdata, 32'h5678AABB);
    @(posedge clk); #1;
    chk("bp_idle_ready", req_ready, 1); chk("bp_idle_rv", resp_valid, 0);
    chk("bp_idle_rd", mem_rd_en, 0);
    @(posedge clk); #1;
    chk("bp_2nd_accept", mem_rd_en, 1); chk("bp_2nd_ready", req_ready, 0);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp_2nd_lat", lat, 3); chk("bp_2nd_data", resp_rdata, 32'h5678AABB);
    repeat (5) @(posedge clk);

    // Delayed rd_valid stretches WAIT by exactly the delay
    extra = 3;
    do_req(0, 2'd1, 0, 15'h22, 32'h0, lat, rd, er, oc);
    chk("dly_lat", lat, 6); chk("dly_data", rd, 32'h000011AD);
    chk("dly_pulse", oc, 1);
    extra = 0;
    repeat (5) @(posedge clk);

    chk("never_both", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
